msm_scheduler: RTL

MSM_SCHEDULER -- requirements
Module: msm_scheduler

---
 rtl/msm_scheduler_pkg.sv | 27 ++
 rtl/msm_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/msm_scheduler_pkg.sv
// Shared parameters, state encoding and point type for the MSM scheduler.
package params;

  localparam int P_WIDTH = 377;
  localparam int K_WIDTH = 254;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MUL_START = 3'd1,
    MUL_WAIT  = 3'd2,
    ADD_START = 3'd3,
    ADD_WAIT  = 3'd4,
    OUTPUT    = 3'd5
  } state_e;

  // Affine curve point at the default coordinate width.
  typedef struct packed {
    logic [P_WIDTH-1:0] x;
    logic [P_WIDTH-1:0] y;
  } point_t;

  // Batch pair counter that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/msm_scheduler.sv
// Multi-scalar-multiplication scheduler: feeds (k, P) pairs one at a time to an
// external point multiplier and folds the products into an accumulator through
// an external point adder, emitting the batch sum after the last pair.
module msm_scheduler #(
  parameter int P_WIDTH = params::P_WIDTH,
  parameter int K_WIDTH = params::K_WIDTH
) (
  input  logic               clk,
  input  logic               Reset_n,
  // pair input
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [K_WIDTH-1:0] in_k,
  input  logic [P_WIDTH-1:0] in_px,
  input  logic [P_WIDTH-1:0] in_py,
  // multiplier core
  output logic               mul_start,
  output logic [K_WIDTH-1:0] mul_k,
  output logic [P_WIDTH-1:0] mul_px,
  output logic [P_WIDTH-1:0] mul_py,
  input  logic               mul_done,
  input  logic [P_WIDTH-1:0] mul_rx,
  input  logic [P_WIDTH-1:0] mul_ry,
  // adder core
  output logic               add_start,
  output logic [P_WIDTH-1:0] add_ax,
  output logic [P_WIDTH-1:0] add_ay,
  output logic [P_WIDTH-1:0] add_bx,
  output logic [P_WIDTH-1:0] add_by,
  input  logic               add_done,
  input  logic [P_WIDTH-1:0] add_rx,
  input  logic [P_WIDTH-1:0] add_ry,
  // result
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] out_x,
  output logic [P_WIDTH-1:0] out_y,
  output logic               out_inf,
  output logic [7:0]         out_count
);

  import params::*;

  state_e             state_q, state_d;
  logic [K_WIDTH-1:0] k_q, k_d;
  logic [P_WIDTH-1:0] px_q, px_d, py_q, py_d;
  logic               last_q, last_d;
  logic [7:0]         count_q, count_d;
  logic [P_WIDTH-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic               empty_q, empty_d;
  logic [P_WIDTH-1:0] prod_x_q, prod_x_d, prod_y_q, prod_y_d;
  logic               accept;

  // Gating with Reset_n keeps in_ready low while reset is held even though the
  // state register already reads IDLE.
  assign in_ready  = (state_q == IDLE) && Reset_n;
  assign accept    = in_valid && in_ready;

  assign mul_start = (state_q == MUL_START);
  assign mul_k     = k_q;
  assign mul_px    = px_q;
  assign mul_py    = py_q;

  assign add_start = (state_q == ADD_START);
  assign add_ax    = acc_x_q;
  assign add_ay    = acc_y_q;
  assign add_bx    = prod_x_q;
  assign add_by    = prod_y_q;

  // The accumulator is held at zero while empty, so out_x/out_y read 0 for infinity.
  assign out_valid = (state_q == OUTPUT);
  assign out_x     = acc_x_q;
  assign out_y     = acc_y_q;
  assign out_inf   = (state_q == OUTPUT) && empty_q;
  assign out_count = count_q;

  // Next-state and datapath-update decode; done strobes count only in their wait state.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    px_d     = px_q;
    py_d     = py_q;
    last_d   = last_q;
    count_d  = count_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    empty_d  = empty_q;
    prod_x_d = prod_x_q;
    prod_y_d = prod_y_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          k_d     = in_k;
          px_d    = in_px;
          py_d    = in_py;
          last_d  = in_last;
          count_d = sat_inc8(count_q);
          // A zero scalar contributes the point at infinity: skip the cores.
          if (in_k != '0)   state_d = MUL_START;
          else if (in_last) state_d = OUTPUT;
        end
      end
      MUL_START: state_d = MUL_WAIT;
      MUL_WAIT: begin
        if (mul_done) begin
          if (empty_q) begin
            acc_x_d = mul_rx;
            acc_y_d = mul_ry;
            empty_d = 1'b0;
            state_d = last_q ? OUTPUT : IDLE;
          end else begin
            prod_x_d = mul_rx;
            prod_y_d = mul_ry;
            state_d  = ADD_START;
          end
        end
      end
      ADD_START: state_d = ADD_WAIT;
      ADD_WAIT: begin
        if (add_done) begin
          acc_x_d = add_rx;
          acc_y_d = add_ry;
          state_d = last_q ? OUTPUT : IDLE;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          acc_x_d = '0;
          acc_y_d = '0;
          empty_d = 1'b1;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and operand registers; reset abandons any batch in flight.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      px_q     <= '0;
      py_q     <= '0;
      last_q   <= 1'b0;
      count_q  <= '0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      empty_q  <= 1'b1;
      prod_x_q <= '0;
      prod_y_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      px_q     <= px_d;
      py_q     <= py_d;
      last_q   <= last_d;
      count_q  <= count_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      empty_q  <= empty_d;
      prod_x_q <= prod_x_d;
      prod_y_q <= prod_y_d;
    end
  end

endmodule
